oled_spi_monitor: RTL

Receive-side model of the OLED panel's 4-wire SPI write interface. Samples `oled_csn`/`oled_clk`/`oled_dat`/`oled_dcn`/`oled_rst` as driven by the OLED12864 transmitter and reassembles bytes tagged command/data. Decodes the SSD1306 page-addressing subset into GDDRAM write strobes (page, column, byte). Used in loopback self-check and simulation, so the display stream can be scored without a panel.

---
 rtl/oled_spi_monitor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/oled_spi_monitor.sv
// Receive-side model of the OLED 4-wire SPI write port: rebuilds command/data bytes and GDDRAM writes.
// Latency: byte_vld/ram_we SYNC_STAGES+2 sys_clk after the 8th oled_clk rise; no backpressure (observer only).
module oled_spi_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int COL_MAX     = 127
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        oled_csn,
  input  logic        oled_rst,
  input  logic        oled_dcn,
  input  logic        oled_clk,
  input  logic        oled_dat,
  output logic        byte_vld,
  output logic [7:0]  byte_dat,
  output logic        byte_dc,
  output logic        ram_we,
  output logic [2:0]  ram_page,
  output logic [6:0]  ram_col,
  output logic [7:0]  ram_dat,
  output logic        frame_err,
  output logic [15:0] cmd_cnt,
  output logic [15:0] dat_cnt
);

  localparam logic [1:0] ST_CMD  = 2'd0;
  localparam logic [1:0] ST_ARG2 = 2'd1;
  localparam logic [1:0] ST_ARG1 = 2'd2;
  localparam logic [6:0] LP_COL_MAX = 7'(COL_MAX);

  // Pin order inside each synchronizer word: {csn, rst, dcn, clk, dat}
  logic [4:0]  r_sync [SYNC_STAGES];
  logic [4:0]  w_pins;
  logic        w_csn_s, w_rst_s, w_dcn_s, w_clk_s, w_dat_s;
  logic        w_csn_rise, w_csn_fall;
  logic        r_clk_hist, r_csn_hist;
  logic        r_rise, r_dat_d, r_dc_d;
  logic        r_armed;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_sr;
  logic        r_byte_vld, r_byte_dc, r_ram_we, r_frame_err;
  logic [7:0]  r_byte_dat, r_ram_dat;
  logic [1:0]  r_state;
  logic [2:0]  r_page;
  logic [6:0]  r_col;
  logic [15:0] r_cmd_cnt, r_dat_cnt;
  logic        w_arg1, w_arg2;

  assign w_pins = {oled_csn, oled_rst, oled_dcn, oled_clk, oled_dat};
  assign {w_csn_s, w_rst_s, w_dcn_s, w_clk_s, w_dat_s} = r_sync[SYNC_STAGES-1];
  assign w_csn_rise = w_csn_s & ~r_csn_hist;
  assign w_csn_fall = ~w_csn_s & r_csn_hist;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Edge detect is registered, so dat/dcn get one matching delay stage.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_clk_hist <= 1'b0;
      r_csn_hist <= 1'b0;
      r_rise     <= 1'b0;
      r_dat_d    <= 1'b0;
      r_dc_d     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_clk_hist <= w_clk_s;
      r_csn_hist <= w_csn_s;
      r_rise     <= w_clk_s & ~r_clk_hist;
      r_dat_d    <= w_dat_s;
      r_dc_d     <= w_dcn_s;
      if (w_csn_fall) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bit_cnt   <= '0;
      r_sr        <= '0;
      r_byte_vld  <= 1'b0;
      r_byte_dat  <= '0;
      r_byte_dc   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_dat   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_ram_we    <= 1'b0;
      r_frame_err <= w_csn_rise && (r_bit_cnt != 3'd0);
      if (!w_rst_s) begin
        r_bit_cnt <= '0;
        r_sr      <= '0;
      end else if (w_csn_s) begin
        r_bit_cnt <= '0;
      end else if (r_rise && r_armed) begin
        r_sr <= {r_sr[5:0], r_dat_d};
        if (r_bit_cnt == 3'd7) begin
          r_bit_cnt  <= '0;
          r_byte_vld <= 1'b1;
          r_byte_dat <= {r_sr, r_dat_d};
          r_byte_dc  <= r_dc_d;
          r_ram_we   <= r_dc_d;
          r_ram_dat  <= {r_sr, r_dat_d};
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  // Commands followed by one or two argument bytes that must not be decoded.
  always_comb begin
    w_arg1 = 1'b0;
    w_arg2 = 1'b0;
    case (r_byte_dat)
      8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5,
      8'hD9, 8'hDA, 8'hDB, 8'h8D: w_arg1 = 1'b1;
      8'h21, 8'h22:               w_arg2 = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_CMD;
      r_page  <= '0;
      r_col   <= '0;
    end else if (!w_rst_s) begin
      r_state <= ST_CMD;
      r_page  <= '0;
      r_col   <= '0;
    end else if (r_byte_vld) begin
      if (r_byte_dc) begin
        r_col <= (r_col == LP_COL_MAX) ? 7'd0 : r_col + 7'd1;
      end else begin
        case (r_state)
          ST_ARG2: r_state <= ST_ARG1;
          ST_ARG1: r_state <= ST_CMD;
          default: begin
            if (r_byte_dat[7:4] == 4'h0)        r_col[3:0] <= r_byte_dat[3:0];
            else if (r_byte_dat[7:3] == 5'h02)  r_col[6:4] <= r_byte_dat[2:0];
            else if (r_byte_dat[7:3] == 5'h16)  r_page     <= r_byte_dat[2:0];
            else if (w_arg1)                    r_state    <= ST_ARG1;
            else if (w_arg2)                    r_state    <= ST_ARG2;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd_cnt <= '0;
      r_dat_cnt <= '0;
    end else if (r_byte_vld && w_rst_s) begin
      if (r_byte_dc) begin
        if (r_dat_cnt != 16'hFFFF) r_dat_cnt <= r_dat_cnt + 16'd1;
      end else begin
        if (r_cmd_cnt != 16'hFFFF) r_cmd_cnt <= r_cmd_cnt + 16'd1;
      end
    end
  end

  assign byte_vld  = r_byte_vld;
  assign byte_dat  = r_byte_dat;
  assign byte_dc   = r_byte_dc;
  assign ram_we    = r_ram_we;
  assign ram_page  = r_page;
  assign ram_col   = r_col;
  assign ram_dat   = r_ram_dat;
  assign frame_err = r_frame_err;
  assign cmd_cnt   = r_cmd_cnt;
  assign dat_cnt   = r_dat_cnt;

endmodule
